pe_ctx_seq: RTL and testbench

PE_CTX_SEQ -- requirements
Module: pe_ctx_seq

---
 rtl/pe_ctx_pkg.sv | 109 ++++++++++
 rtl/pe_ctx_mem.sv | 27 ++
 rtl/pe_ctx_seq.sv | 188 ++++++++++++++++++
 tb/tb_pe_ctx_seq.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_ctx_pkg.sv
// Shared definitions for the PE context sequencer: context word layout, FSM encoding,
// control decode constants and the registered control bundle driven to the PE register file.
package pe_ctx_pkg;

    localparam int CTX_W = 48;

    // Context word field offsets, LSB first
    localparam int F_IN_SEL   = 0;
    localparam int F_PUT_IN   = 3;
    localparam int F_REG1     = 9;
    localparam int F_REG2     = 15;
    localparam int F_FU1_SEL  = 21;
    localparam int F_FU2_SEL  = 24;
    localparam int F_PUT_OUT  = 27;
    localparam int F_SEND     = 33;
    localparam int F_OUT_MASK = 39;
    localparam int F_WB       = 43;
    localparam int F_LDW      = 44;
    localparam int F_LD       = 45;
    localparam int F_PRED_USE = 46;
    localparam int F_RSVD     = 47;

    localparam int W_SEL  = 3;
    localparam int W_REG  = 6;
    localparam int W_MASK = 4;
    localparam int W_CIN  = 9;
    localparam int W_FU   = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam logic [W_CIN-1:0] IN_SEL_1 = 9'b000001000;
    localparam logic [W_CIN-1:0] IN_SEL_2 = 9'b000000001;
    localparam logic [W_CIN-1:0] IN_SEL_3 = 9'b000000010;
    localparam logic [W_CIN-1:0] IN_SEL_4 = 9'b000010000;

    localparam logic [W_FU-1:0] FU_SEL_1 = 4'b0100;
    localparam logic [W_FU-1:0] FU_SEL_2 = 4'b0001;
    localparam logic [W_FU-1:0] FU_SEL_3 = 4'b0010;
    localparam logic [W_FU-1:0] FU_SEL_4 = 4'b1000;

    // control_out bit driven by each out_mask bit
    localparam int OM_BIT3 = 4;
    localparam int OM_BIT2 = 1;
    localparam int OM_BIT1 = 0;
    localparam int OM_BIT0 = 3;

    typedef struct packed {
        logic [W_CIN-1:0] ctl_in;
        logic [W_CIN-1:0] ctl_out;
        logic [W_REG-1:0] put_in;
        logic [W_REG-1:0] put_out;
        logic [W_REG-1:0] reg_1;
        logic [W_REG-1:0] reg_2;
        logic [W_REG-1:0] send;
        logic [W_FU-1:0]  pe2fu_1;
        logic [W_FU-1:0]  pe2fu_2;
        logic             write_back;
        logic             ld;
        logic             ld_write;
    } ctrl_t;

    // Safe bundle: everything quiet, register-file writes suppressed
    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c    = '0;
        c.ld = 1'b1;
        return c;
    endfunction

    function automatic logic [W_CIN-1:0] dec_in_sel(input logic [W_SEL-1:0] sel);
        logic [W_CIN-1:0] v;
        case (sel)
            3'd1:    v = IN_SEL_1;
            3'd2:    v = IN_SEL_2;
            3'd3:    v = IN_SEL_3;
            3'd4:    v = IN_SEL_4;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [W_FU-1:0] dec_fu_sel(input logic [W_SEL-1:0] sel);
        logic [W_FU-1:0] v;
        case (sel)
            3'd1:    v = FU_SEL_1;
            3'd2:    v = FU_SEL_2;
            3'd3:    v = FU_SEL_3;
            3'd4:    v = FU_SEL_4;
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [W_CIN-1:0] map_out_mask(input logic [W_MASK-1:0] m);
        logic [W_CIN-1:0] v;
        v          = '0;
        v[OM_BIT3] = m[3];
        v[OM_BIT2] = m[2];
        v[OM_BIT1] = m[1];
        v[OM_BIT0] = m[0];
        return v;
    endfunction

endpackage

// File: rtl/pe_ctx_mem.sv
// Context word store: one synchronous write port, one asynchronous read port, no reset.
// Read latency 0 (combinational); writes land on the next core_clk edge, no backpressure.
// Contents are undefined until written.
module pe_ctx_mem #(
    parameter  int DEPTH = 16,
    parameter  int W     = 48,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          core_clk,
    input  logic          wr_vld,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_dat,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_dat
);

    logic [W-1:0] ctx_mem [DEPTH];

    always_ff @(posedge core_clk) begin
        if (wr_vld) begin
            ctx_mem[wr_addr] <= wr_dat;
        end
    end

    assign rd_dat = ctx_mem[rd_addr];

endmodule

// File: rtl/pe_ctx_seq.sv
// PE context sequencer: loads context words, then replays ctx 0..ctx_last for iter_num loops.
// Latency: control outputs registered 1 cycle after ctx_idx; cfg_ready drops outside IDLE/LOAD.
// Optional predication of write_back selected by macro PE_CTX_PRED_EN (adds input pred_in).
module pe_ctx_seq #(
    parameter  int CTX_DEPTH = 16,
    parameter  int CTX_W     = pe_ctx_pkg::CTX_W,
    localparam int IDX_W     = $clog2(CTX_DEPTH)
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CTX_W-1:0] cfg_data,
    input  logic [IDX_W-1:0] ctx_last,
    input  logic [7:0]       iter_num,
    input  logic             start,
    input  logic             stop,
`ifdef PE_CTX_PRED_EN
    input  logic             pred_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] ctx_idx,
    output logic [8:0]       control_in,
    output logic [8:0]       control_out,
    output logic [5:0]       control_put_in,
    output logic [5:0]       control_put_out,
    output logic [5:0]       control_reg_1,
    output logic [5:0]       control_reg_2,
    output logic [5:0]       control_send,
    output logic [3:0]       control_pe2fu_1,
    output logic [3:0]       control_pe2fu_2,
    output logic             write_back,
    output logic             ld,
    output logic             ld_write
);

    import pe_ctx_pkg::*;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ctx_idx_q, ctx_idx_d;
    logic [7:0]       iter_q, iter_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;
    logic             cfg_ready_q, cfg_ready_d;
    ctrl_t            ctrl_q, ctrl_d;
    ctrl_t            run_ctrl;
    logic             mem_we;
    logic [CTX_W-1:0] rd_word;
    logic             last_ctx;
    logic             last_iter;

    pe_ctx_mem #(
        .DEPTH (CTX_DEPTH),
        .W     (CTX_W)
    ) u_mem (
        .core_clk (CLK),
        .wr_vld   (mem_we),
        .wr_addr  (cfg_addr),
        .wr_dat   (cfg_data),
        .rd_addr  (ctx_idx_q),
        .rd_dat   (rd_word)
    );

    // Decode of the word currently addressed by ctx_idx
    always_comb begin
        run_ctrl         = '0;
        run_ctrl.ctl_in  = dec_in_sel(rd_word[F_IN_SEL +: W_SEL]);
        run_ctrl.ctl_out = map_out_mask(rd_word[F_OUT_MASK +: W_MASK]);
        run_ctrl.put_in  = rd_word[F_PUT_IN +: W_REG];
        run_ctrl.put_out = rd_word[F_PUT_OUT +: W_REG];
        run_ctrl.reg_1   = rd_word[F_REG1 +: W_REG];
        run_ctrl.reg_2   = rd_word[F_REG2 +: W_REG];
        run_ctrl.send    = rd_word[F_SEND +: W_REG];
        run_ctrl.pe2fu_1 = dec_fu_sel(rd_word[F_FU1_SEL +: W_SEL]);
        run_ctrl.pe2fu_2 = dec_fu_sel(rd_word[F_FU2_SEL +: W_SEL]);
        run_ctrl.ld      = rd_word[F_LD];
        run_ctrl.ld_write = rd_word[F_LDW];
`ifdef PE_CTX_PRED_EN
        run_ctrl.write_back = rd_word[F_WB] && (!rd_word[F_PRED_USE] || pred_in);
`else
        run_ctrl.write_back = rd_word[F_WB];
`endif
    end

`ifdef PE_CTX_PRED_EN
    logic unused_rsvd;
    assign unused_rsvd = ^rd_word[CTX_W-1:F_RSVD];
`else
    logic unused_rsvd;
    assign unused_rsvd = ^{rd_word[CTX_W-1:F_RSVD], rd_word[F_PRED_USE]};
`endif

    assign last_ctx  = (ctx_idx_q == ctx_last);
    // iter_num of 0 wraps to 8'hFF here, giving 256 passes
    assign last_iter = (iter_q == 8'(iter_num - 8'd1));

    always_comb begin
        state_d   = state_q;
        ctx_idx_d = ctx_idx_q;
        iter_d    = iter_q;
        done_d    = 1'b0;
        ctrl_d    = ctrl_idle();
        mem_we    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                mem_we = cfg_valid && cfg_ready_q;
                if (start) begin
                    state_d   = ST_RUN;
                    ctx_idx_d = '0;
                    iter_d    = '0;
                end else if (cfg_valid) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                mem_we = cfg_valid && cfg_ready_q;
                if (!cfg_valid) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_DRAIN;
                end else begin
                    ctrl_d = run_ctrl;
                    if (last_ctx) begin
                        ctx_idx_d = '0;
                        iter_d    = iter_q + 8'd1;
                        if (last_iter) begin
                            state_d = ST_DRAIN;
                            done_d  = 1'b1;
                        end
                    end else begin
                        ctx_idx_d = ctx_idx_q + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d      = (state_d == ST_RUN) || (state_d == ST_DRAIN);
        cfg_ready_d = (state_d == ST_IDLE) || (state_d == ST_LOAD);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= ST_IDLE;
            ctx_idx_q   <= '0;
            iter_q      <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            cfg_ready_q <= 1'b0;
            ctrl_q      <= ctrl_idle();
        end else begin
            state_q     <= state_d;
            ctx_idx_q   <= ctx_idx_d;
            iter_q      <= iter_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            cfg_ready_q <= cfg_ready_d;
            ctrl_q      <= ctrl_d;
        end
    end

    assign cfg_ready       = cfg_ready_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign ctx_idx         = ctx_idx_q;
    assign control_in      = ctrl_q.ctl_in;
    assign control_out     = ctrl_q.ctl_out;
    assign control_put_in  = ctrl_q.put_in;
    assign control_put_out = ctrl_q.put_out;
    assign control_reg_1   = ctrl_q.reg_1;
    assign control_reg_2   = ctrl_q.reg_2;
    assign control_send    = ctrl_q.send;
    assign control_pe2fu_1 = ctrl_q.pe2fu_1;
    assign control_pe2fu_2 = ctrl_q.pe2fu_2;
    assign write_back      = ctrl_q.write_back;
    assign ld              = ctrl_q.ld;
    assign ld_write        = ctrl_q.ld_write;

endmodule

// File: tb/tb_pe_ctx_seq.sv
// Directed bench for pe_ctx_seq: load, full run, decode, stop, async reset, optional predication.
module tb_pe_ctx_seq;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [3:0]  cfg_addr;
    logic [47:0] cfg_data;
    logic [3:0]  ctx_last;
    logic [7:0]  iter_num;
    logic        start;
    logic        stop;
`ifdef PE_CTX_PRED_EN
    logic        pred_in;
`endif
    logic        busy;
    logic        done;
    logic [3:0]  ctx_idx;
    logic [8:0]  control_in;
    logic [8:0]  control_out;
    logic [5:0]  control_put_in;
    logic [5:0]  control_put_out;
    logic [5:0]  control_reg_1;
    logic [5:0]  control_reg_2;
    logic [5:0]  control_send;
    logic [3:0]  control_pe2fu_1;
    logic [3:0]  control_pe2fu_2;
    logic        write_back;
    logic        ld;
    logic        ld_write;

    pe_ctx_seq dut (
        .CLK             (CLK),
        .RST_N           (RST_N),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_addr        (cfg_addr),
        .cfg_data        (cfg_data),
        .ctx_last        (ctx_last),
        .iter_num        (iter_num),
        .start           (start),
        .stop            (stop),
`ifdef PE_CTX_PRED_EN
        .pred_in         (pred_in),
`endif
        .busy            (busy),
        .done            (done),
        .ctx_idx         (ctx_idx),
        .control_in      (control_in),
        .control_out     (control_out),
        .control_put_in  (control_put_in),
        .control_put_out (control_put_out),
        .control_reg_1   (control_reg_1),
        .control_reg_2   (control_reg_2),
        .control_send    (control_send),
        .control_pe2fu_1 (control_pe2fu_1),
        .control_pe2fu_2 (control_pe2fu_2),
        .write_back      (write_back),
        .ld              (ld),
        .ld_write        (ld_write)
    );

    always #5 CLK = ~CLK;

    localparam logic [58:0] IDLE_VEC = 59'd2;

    int          n_cmp = 0;
    int          n_err = 0;
    int          done_seen;
    logic [58:0] sb [$];
    logic [47:0] wd [4];
    logic [8:0]  in_tab [8] = '{9'h000, 9'h008, 9'h001, 9'h002, 9'h010, 9'h000, 9'h000, 9'h000};
    logic [3:0]  fu_tab [8] = '{4'h0, 4'h4, 4'h1, 4'h2, 4'h8, 4'h0, 4'h0, 4'h0};

    function automatic logic [47:0] mk_word(input logic [2:0] isel, input logic [5:0] pin,
            input logic [5:0] r1, input logic [5:0] r2, input logic [2:0] f1, input logic [2:0] f2,
            input logic [5:0] pout, input logic [5:0] snd, input logic [3:0] mask,
            input logic wb, input logic ldw, input logic ldv, input logic pu);
        return {1'b0, pu, ldv, ldw, wb, mask, snd, pout, f2, f1, r2, r1, pin, isel};
    endfunction

    function automatic logic [58:0] model(input logic [47:0] w);
        logic [8:0] co;
        logic [3:0] m;
        logic       wbv;
        m  = w[42:39];
        co = 9'd0;
        if (m[3]) co = co | 9'h010;
        if (m[2]) co = co | 9'h002;
        if (m[1]) co = co | 9'h001;
        if (m[0]) co = co | 9'h008;
`ifdef PE_CTX_PRED_EN
        wbv = w[43] & (~w[46] | pred_in);
`else
        wbv = w[43];
`endif
        return {in_tab[w[2:0]], co, w[8:3], w[32:27], w[14:9], w[20:15], w[38:33],
                fu_tab[w[23:21]], fu_tab[w[26:24]], wbv, w[45], w[44]};
    endfunction

    function automatic logic [58:0] obs_vec();
        return {control_in, control_out, control_put_in, control_put_out, control_reg_1,
                control_reg_2, control_send, control_pe2fu_1, control_pe2fu_2,
                write_back, ld, ld_write};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pop_cmp(input string tag);
        logic [58:0] e;
        e = (sb.size() > 0) ? sb.pop_front() : 'x;
        chk(tag, {5'd0, obs_vec()}, {5'd0, e});
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N     = 1'b0;
        cfg_valid = 1'b0;
        cfg_addr  = '0;
        cfg_data  = '0;
        ctx_last  = '0;
        iter_num  = '0;
        start     = 1'b0;
        stop      = 1'b0;
`ifdef PE_CTX_PRED_EN
        pred_in   = 1'b1;
`endif
        wd[0] = mk_word(3'd4, 6'h15, 6'h03, 6'h07, 3'd2, 3'd3, 6'h2a, 6'h11, 4'b1001, 1'b1, 1'b1, 1'b0, 1'b0);
        wd[1] = mk_word(3'd1, 6'h01, 6'h3f, 6'h20, 3'd1, 3'd4, 6'h05, 6'h3f, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1);
        wd[2] = mk_word(3'd2, 6'h2e, 6'h11, 6'h0c, 3'd4, 3'd0, 6'h13, 6'h22, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1);
        wd[3] = mk_word(3'd7, 6'h0a, 6'h01, 6'h02, 3'd3, 3'd1, 6'h04, 6'h08, 4'b0100, 1'b1, 1'b1, 1'b1, 1'b1);

        // Reset state
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cfg_ready", cfg_ready, 0);
        chk("rst_ctx_idx", ctx_idx, 0);
        chk("rst_outputs", {5'd0, obs_vec()}, {5'd0, IDLE_VEC});
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("idle_cfg_ready", cfg_ready, 1);

        // Load three context words back-to-back
        cfg_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cfg_addr = 4'(i);
            cfg_data = wd[i];
            tick();
            chk("load_cfg_ready", cfg_ready, 1);
        end
        cfg_valid = 1'b0;
        tick();

        // Full run: two iterations over contexts 0..2
        ctx_last = 4'd2;
        iter_num = 8'd2;
        start    = 1'b1;
        tick();
        start     = 1'b0;
        done_seen = 0;
        chk("run_busy", busy, 1);
        chk("run_first_outputs_idle", {5'd0, obs_vec()}, {5'd0, IDLE_VEC});
        for (int k = 0; k < 6; k++) begin
            chk("run_ctx_idx", ctx_idx, 64'(k % 3));
            if (done) done_seen++;
            if (k > 0) pop_cmp("run_outputs");
            if (k == 1) begin
                chk("dec_control_in", control_in, 9'h010);
                chk("dec_pe2fu_1", control_pe2fu_1, 4'b0001);
                chk("dec_control_out", control_out, 9'b000011000);
            end
            sb.push_back(model(wd[k % 3]));
            tick();
        end
        pop_cmp("run_last_outputs");
        chk("run_done_pulse", done, 1);
        chk("run_busy_drain", busy, 1);
        tick();
        if (done) done_seen++;
        chk("run_done_once", done_seen, 0);
        chk("run_busy_fall", busy, 0);
        chk("run_outputs_after", {5'd0, obs_vec()}, {5'd0, IDLE_VEC});
        chk("run_sb_empty", sb.size(), 0);

        // Stop during the second iteration
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("stop_ctx_idx", ctx_idx, 64'(k % 3));
            if (k > 0) pop_cmp("stop_outputs");
            sb.push_back(model(wd[k % 3]));
            tick();
        end
        chk("stop_ctx_idx_pre", ctx_idx, 1);
        pop_cmp("stop_outputs_pre");
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_no_done_1", done, 0);
        chk("stop_outputs_idle", {5'd0, obs_vec()}, {5'd0, IDLE_VEC});
        tick();
        chk("stop_no_done_2", done, 0);
        chk("stop_busy", busy, 0);
        chk("stop_cfg_ready", cfg_ready, 1);
        chk("stop_outputs_idle_2", {5'd0, obs_vec()}, {5'd0, IDLE_VEC});
        tick();
        chk("stop_no_done_3", done, 0);

        // Asynchronous reset in the middle of a long run
        iter_num = 8'd0;
        start    = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("arst_pre_outputs", {5'd0, obs_vec()}, {5'd0, model(wd[1])});
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst_outputs", {5'd0, obs_vec()}, {5'd0, IDLE_VEC});
        chk("arst_ctx_idx", ctx_idx, 0);
        chk("arst_busy", busy, 0);
        chk("arst_done", done, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        tick();
        chk("arst_cfg_ready", cfg_ready, 1);
        chk("arst_outputs_after", {5'd0, obs_vec()}, {5'd0, IDLE_VEC});
        tick();
        chk("arst_no_done", done, 0);
        chk("arst_busy_after", busy, 0);

`ifdef PE_CTX_PRED_EN
        // Predicated write-back: same word, pred_in low then high
        cfg_valid = 1'b1;
        cfg_addr  = 4'd0;
        cfg_data  = wd[3];
        tick();
        cfg_valid = 1'b0;
        tick();
        ctx_last = 4'd0;
        iter_num = 8'd2;
        start    = 1'b1;
        tick();
        start   = 1'b0;
        pred_in = 1'b0;
        sb.push_back(model(wd[3]));
        tick();
        pop_cmp("pred0_outputs");
        chk("pred0_write_back", write_back, 0);
        pred_in = 1'b1;
        sb.push_back(model(wd[3]));
        tick();
        pop_cmp("pred1_outputs");
        chk("pred1_write_back", write_back, 1);
        chk("pred_done", done, 1);
        tick();
        chk("pred_busy_fall", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
